mem_interface: RTL and testbench

- Memory-access stage sitting between the microprogrammed controller and external word memory.
- Holds MAR and MDR and runs a request/acknowledge handshake to a variable-latency memory.
- Drives the wait_ condition input that the controller's microsequencer branches on.
- Read/write strobes and register-load enables come from decoded bus_controller bits; the address and write data come from the CPU internal bus.

---
 rtl/mem_interface.sv | 118 +++++++++++
 tb/tb_mem_interface.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// Memory-access stage: holds MAR/MDR and runs a req/ack handshake to a
// variable-latency word memory, raising wait_ to stall the microsequencer.
module mem_interface #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] bus_in,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              wait_,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              err_q, err_d;
  // Snapshot of MAR/MDR taken by the strobe, so a same-edge load does not
  // leak into the access that the strobe started.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy;
  logic              timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy    = (state_q != IDLE);
    timeout = busy && !m_ack && (cnt_q == CNT_LAST);

    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ld_mar) mar_d = bus_in[ADDR_W-1:0];
        if (ld_mdr) mdr_d = bus_in;
        if (mem_wr || mem_rd) begin
          state_d = mem_wr ? WR : RD;
          cnt_d   = '0;
          addr_d  = mar_q;
          wdata_d = mdr_q;
        end
      end
      RD, WR: begin
        if (m_ack) begin
          state_d = IDLE;
          if (state_q == RD) mdr_d = m_rdata;
        end else if (timeout) begin
          // Abort; a timeout set has priority over a same-cycle err_clr.
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mar_out = mar_q;
  assign mdr_out = mdr_q;
  assign err     = err_q;
  assign m_req   = (state_q != IDLE);
  assign wait_   = (state_q != IDLE);
  assign m_we    = (state_q == WR);
  assign m_addr  = busy ? addr_q  : mar_q;
  assign m_wdata = busy ? wdata_q : mdr_q;

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: the bench plays the memory and keeps
// its own MAR/MDR/err model plus a word array standing in for external memory.
module tb_mem_interface;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_mar = 1'b0, ld_mdr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic              err_clr = 1'b0, m_ack = 1'b0;
  logic [DATA_W-1:0] bus_in = '0, m_rdata = '0;
  logic [ADDR_W-1:0] mar_out, m_addr;
  logic [DATA_W-1:0] mdr_out, m_wdata;
  logic              wait_, err, m_req, m_we;

  mem_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .err_clr(err_clr), .bus_in(bus_in),
    .mar_out(mar_out), .mdr_out(mdr_out), .wait_(wait_), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] mdl_mar = '0;
  logic [DATA_W-1:0] mdl_mdr = '0;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // All tasks start and end just after a falling edge.
  task automatic load(input bit to_mar, input logic [DATA_W-1:0] v);
    bus_in = v; ld_mar = to_mar; ld_mdr = !to_mar;
    @(negedge clk);
    ld_mar = 1'b0; ld_mdr = 1'b0;
    if (to_mar) mdl_mar = v[ADDR_W-1:0]; else mdl_mdr = v;
    n_checks++;
    if (mar_out !== mdl_mar || mdr_out !== mdl_mdr) begin
      n_fail++;
      $display("FAIL load: mar=%h mdr=%h expected mar=%h mdr=%h", mar_out, mdr_out, mdl_mar, mdl_mdr);
    end
  endtask

  // Issue strobes, act as memory acking in busy cycle lat (0 = never ack).
  task automatic do_access(input bit wr, input bit rd, input int lat, input bit noise,
                           input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ewd,
                           output int cycles);
    mem_wr = wr; mem_rd = rd;
    @(negedge clk);
    mem_wr = 1'b0; mem_rd = 1'b0;
    cycles = 0;
    while (wait_ === 1'b1 && cycles < 4*TIMEOUT) begin
      cycles++;
      n_checks++;
      if (m_req !== 1'b1 || m_we !== wr || m_addr !== ea || (wr && m_wdata !== ewd)) begin
        n_fail++;
        $display("FAIL busy_outputs: req=%b we=%b addr=%h wdata=%h expected req=1 we=%b addr=%h wdata=%h",
                 m_req, m_we, m_addr, m_wdata, wr, ea, ewd);
      end
      if (noise) begin
        ld_mar = 1'b1; ld_mdr = 1'b1; mem_rd = 1'b1; bus_in = 16'($urandom);
      end
      if (cycles == lat) begin
        m_ack = 1'b1;
        if (wr) mem[m_addr] = m_wdata;
        else    m_rdata = mem[m_addr];
      end
      @(negedge clk);
      m_ack = 1'b0; m_rdata = 16'($urandom);
    end
    ld_mar = 1'b0; ld_mdr = 1'b0; mem_rd = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (mar_out !== '0 || mdr_out !== '0 || wait_ !== 1'b0 || err !== 1'b0 ||
        m_req !== 1'b0 || m_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: mar=%h mdr=%h wait=%b err=%b req=%b we=%b expected all 0",
               mar_out, mdr_out, wait_, err, m_req, m_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_read;
    int c;
    load(1'b1, 16'h0ABC);
    mem[12'hABC] = 16'hBEEF;
    do_access(1'b0, 1'b1, 1, 1'b0, 12'hABC, mdl_mdr, c);
    mdl_mdr = 16'hBEEF;
    n_checks++;
    if (c != 1 || mdr_out !== 16'hBEEF || wait_ !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_wait_read: wait_cycles=%0d mdr=%h expected 1 cycle mdr=beef", c, mdr_out);
    end
  endtask

  task automatic test_delayed_write;
    int c;
    logic [ADDR_W-1:0] ea;
    load(1'b0, 16'h5A5A);
    ea = mdl_mar;
    do_access(1'b1, 1'b0, 5, 1'b1, ea, 16'h5A5A, c);
    n_checks++;
    if (c != 5 || mem[ea] !== 16'h5A5A || mar_out !== ea || mdr_out !== 16'h5A5A || wait_ !== 1'b0) begin
      n_fail++;
      $display("FAIL delayed_write: wait_cycles=%0d mem=%h mar=%h mdr=%h expected 5 5a5a %h 5a5a",
               c, mem[ea], mar_out, mdr_out, ea);
    end
  endtask

  task automatic test_both_strobes;
    int c;
    load(1'b0, 16'h1357);
    mem[mdl_mar] = 16'hF00D;
    do_access(1'b1, 1'b1, 2, 1'b0, mdl_mar, 16'h1357, c);
    n_checks++;
    if (c != 2 || mdr_out !== 16'h1357 || mem[mdl_mar] !== 16'h1357 || wait_ !== 1'b0) begin
      n_fail++;
      $display("FAIL both_strobes: wait_cycles=%0d mdr=%h mem=%h expected 2 1357 1357", c, mdr_out, mem[mdl_mar]);
    end
  endtask

  task automatic test_timeout;
    int c;
    load(1'b1, 16'($urandom));
    err_clr = 1'b1;
    do_access(1'b0, 1'b1, 0, 1'b0, mdl_mar, mdl_mdr, c);
    err_clr = 1'b0;
    n_checks++;
    if (c != TIMEOUT || err !== 1'b1 || mdr_out !== mdl_mdr || m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: req_cycles=%0d err=%b mdr=%h req=%b expected %0d 1 %h 0",
               c, err, mdr_out, m_req, TIMEOUT, mdl_mdr);
    end
    m_ack = 1'b1; m_rdata = 16'hDEAD;
    @(negedge clk);
    m_ack = 1'b0;
    n_checks++;
    if (mdr_out !== mdl_mdr || wait_ !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL late_ack: mdr=%h wait=%b err=%b expected %h 0 1", mdr_out, wait_, err, mdl_mdr);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: err=%b expected 0", err);
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    load(1'b1, 16'h0321);
    do_access(1'b0, 1'b1, 1, 1'b0, mdl_mar, mdl_mdr, c1);
    mdl_mdr = mem[mdl_mar];
    do_access(1'b1, 1'b0, 1, 1'b0, mdl_mar, mdl_mdr, c2);
    n_checks++;
    if (c1 != 1 || c2 != 1 || mdr_out !== mdl_mdr || mem[mdl_mar] !== mdl_mdr) begin
      n_fail++;
      $display("FAIL back_to_back: rd_cycles=%0d wr_cycles=%0d mdr=%h expected 1 1 %h", c1, c2, mdr_out, mdl_mdr);
    end
  endtask

  task automatic test_same_cycle_load;
    int c;
    logic [ADDR_W-1:0] old_a, new_a;
    old_a = mdl_mar;
    new_a = old_a ^ 12'h555;
    bus_in = {4'h0, new_a}; ld_mar = 1'b1;
    do_access(1'b0, 1'b1, 1, 1'b0, old_a, mdl_mdr, c);
    mdl_mar = new_a;
    mdl_mdr = mem[old_a];
    n_checks++;
    if (c != 1 || mar_out !== new_a || mdr_out !== mdl_mdr) begin
      n_fail++;
      $display("FAIL same_cycle_load: cycles=%0d mar=%h mdr=%h expected 1 %h %h", c, mar_out, mdr_out, new_a, mdl_mdr);
    end
  endtask

  task automatic test_reset_mid_read;
    load(1'b1, 16'h0123);
    mem_rd = 1'b1;
    @(negedge clk);
    mem_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mdl_mar = '0; mdl_mdr = '0;
    n_checks++;
    if (m_req !== 1'b0 || wait_ !== 1'b0 || mar_out !== '0 || mdr_out !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: req=%b wait=%b mar=%h mdr=%h err=%b expected all 0",
               m_req, wait_, mar_out, mdr_out, err);
    end
    @(negedge clk);
    rst_n = 1'b1; m_ack = 1'b1; m_rdata = 16'h1234;
    @(negedge clk);
    m_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mdr_out !== '0 || m_req !== 1'b0 || wait_ !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_after_reset: mdr=%h req=%b wait=%b expected 0 0 0", mdr_out, m_req, wait_);
    end
  endtask

  task automatic test_random;
    int c, lat, op;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      lat = int'($urandom_range(1, 6));
      case (op)
        0: load(1'b1, 16'($urandom));
        1: load(1'b0, 16'($urandom));
        2: begin
          do_access(1'b0, 1'b1, lat, 1'b0, mdl_mar, mdl_mdr, c);
          mdl_mdr = mem[mdl_mar];
          n_checks++;
          if (c != lat || mdr_out !== mdl_mdr) begin
            n_fail++;
            $display("FAIL random_read: cycles=%0d mdr=%h expected %0d %h", c, mdr_out, lat, mdl_mdr);
          end
        end
        default: begin
          do_access(1'b1, 1'b0, lat, 1'b1, mdl_mar, mdl_mdr, c);
          n_checks++;
          if (c != lat || mem[mdl_mar] !== mdl_mdr || mar_out !== mdl_mar || mdr_out !== mdl_mdr) begin
            n_fail++;
            $display("FAIL random_write: cycles=%0d mem=%h mar=%h mdr=%h expected %0d %h %h %h",
                     c, mem[mdl_mar], mar_out, mdr_out, lat, mdl_mdr, mdl_mar, mdl_mdr);
          end
        end
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'($urandom);
    @(negedge clk);
    @(negedge clk);
    test_reset;
    test_zero_wait_read;
    test_delayed_write;
    test_both_strobes;
    test_timeout;
    test_back_to_back;
    test_same_cycle_load;
    test_random;
    test_reset_mid_read;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
